// File: rtl/param_reg_file.sv
// param_reg_file: parametrised register file with two read buses, one C write
// bus, per-register clear, auto-increment, and a handshaked memory-load path
// with a one-deep load scoreboard and a wait timeout.
module param_reg_file #(
   parameter int unsigned DATA_W   = 19,
   parameter int unsigned MEM_W    = 8,
   parameter int unsigned NREGS    = 14,
   parameter int unsigned SEL_W    = 4,
   parameter int unsigned ADDR_REG = 0,
   parameter int unsigned DATA_REG = 1,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              CLR,
   input  logic [SEL_W-1:0]  CLR_SEL,
   input  logic              C_EN,
   input  logic [SEL_W-1:0]  C_SEL,
   input  logic [DATA_W-1:0] c_in,
   input  logic [SEL_W-1:0]  A_SEL,
   input  logic [SEL_W-1:0]  B_SEL,
   input  logic              INC_EN,
   input  logic [SEL_W-1:0]  INC_SEL,
   input  logic              MEM_READ,
   input  logic [SEL_W-1:0]  MEM_DST,
   input  logic              mem_valid,
   input  logic [MEM_W-1:0]  mem_data,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [DATA_W-1:0] dm_addr,
   output logic [MEM_W-1:0]  dm_data,
   output logic              rd_pending,
   output logic [NREGS-1:0]  busy,
   output logic              err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   logic [DATA_W-1:0] regs [NREGS];
   state_t            state, state_nx;
   logic [SEL_W-1:0]  dst, dst_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              load_wr;
   logic              fsm_err;
   logic              hazard;

   assign rd_pending = (state == ST_WAIT);
   assign dm_addr    = regs[ADDR_REG];
   assign dm_data    = regs[DATA_REG][MEM_W-1:0];

   // Combinational read buses; out-of-range selects read as zero.
   always_comb begin
      a_out = '0;
      b_out = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (32'(A_SEL) == i) a_out = regs[i];
         if (32'(B_SEL) == i) b_out = regs[i];
      end
   end

   // Scoreboard: only the latched destination is busy while a load waits.
   always_comb begin
      busy = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         busy[i] = (state == ST_WAIT) && (32'(dst) == i);
      end
   end

   // C write or INC aimed at a busy register is a hazard.
   always_comb begin
      hazard = 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (busy[i] && ((C_EN && 32'(C_SEL) == i) || (INC_EN && 32'(INC_SEL) == i)))
            hazard = 1'b1;
      end
   end

   // Load FSM next-state: accept in IDLE, wait for data or time out in WAIT.
   always_comb begin
      state_nx = state;
      dst_nx   = dst;
      cnt_nx   = cnt;
      load_wr  = 1'b0;
      fsm_err  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (MEM_READ) begin
               if (32'(MEM_DST) < NREGS) begin
                  dst_nx   = MEM_DST;
                  cnt_nx   = '0;
                  state_nx = ST_WAIT;
               end else begin
                  fsm_err = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (MEM_READ) fsm_err = 1'b1;
            if (mem_valid) begin
               load_wr  = 1'b1;
               state_nx = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               fsm_err  = 1'b1;
               cnt_nx   = '0;
               state_nx = ST_IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // FSM state, latched destination, wait counter and registered error pulse.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
         dst   <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         dst   <= dst_nx;
         cnt   <= cnt_nx;
         err   <= fsm_err | hazard;
      end
   end

   // Register array update with per-register priority CLR > load > C > INC.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (CLR && 32'(CLR_SEL) == i)
               regs[i] <= '0;
            else if (load_wr && 32'(dst) == i)
               regs[i] <= DATA_W'(mem_data);
            else if (C_EN && 32'(C_SEL) == i && !busy[i])
               regs[i] <= c_in;
            else if (INC_EN && 32'(INC_SEL) == i && !busy[i])
               regs[i] <= regs[i] + DATA_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_param_reg_file;

   localparam int DW = 19;
   localparam int MW = 8;
   localparam int NR = 14;
   localparam int SW = 4;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          RST = 1'b1;
   logic          CLR = 1'b0;
   logic [SW-1:0] CLR_SEL = '0;
   logic          C_EN = 1'b0;
   logic [SW-1:0] C_SEL = '0;
   logic [DW-1:0] c_in = '0;
   logic [SW-1:0] A_SEL = '0;
   logic [SW-1:0] B_SEL = '0;
   logic          INC_EN = 1'b0;
   logic [SW-1:0] INC_SEL = '0;
   logic          MEM_READ = 1'b0;
   logic [SW-1:0] MEM_DST = '0;
   logic          mem_valid = 1'b0;
   logic [MW-1:0] mem_data = '0;
   logic [DW-1:0] a_out, b_out, dm_addr;
   logic [MW-1:0] dm_data;
   logic          rd_pending, err;
   logic [NR-1:0] busy;

   int tests = 0;
   int fails = 0;

   // Behavioural model state
   logic [DW-1:0] m_regs [NR] = '{default: '0};
   logic [DW-1:0] nx [NR];
   bit            m_pend = 0;
   int            m_dst = 0;
   int            m_wait = 0;
   bit            m_err = 0;

   param_reg_file #(
      .DATA_W(DW), .MEM_W(MW), .NREGS(NR), .SEL_W(SW),
      .ADDR_REG(0), .DATA_REG(1), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .RST(RST), .CLR(CLR), .CLR_SEL(CLR_SEL),
      .C_EN(C_EN), .C_SEL(C_SEL), .c_in(c_in),
      .A_SEL(A_SEL), .B_SEL(B_SEL),
      .INC_EN(INC_EN), .INC_SEL(INC_SEL),
      .MEM_READ(MEM_READ), .MEM_DST(MEM_DST),
      .mem_valid(mem_valid), .mem_data(mem_data),
      .a_out(a_out), .b_out(b_out), .dm_addr(dm_addr), .dm_data(dm_data),
      .rd_pending(rd_pending), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      CLR = 1'b0; C_EN = 1'b0; INC_EN = 1'b0; MEM_READ = 1'b0; mem_valid = 1'b0;
   endtask

   function automatic logic [31:0] rd(input logic [SW-1:0] s);
      if (int'(s) < NR) return 32'(m_regs[s]);
      return 32'd0;
   endfunction

   // Model: apply sources lowest priority first so higher ones overwrite.
   always @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NR; i++) m_regs[i] = '0;
         m_pend = 0; m_dst = 0; m_wait = 0; m_err = 0;
      end else begin
         automatic bit e = 0;
         automatic int busy_idx = m_pend ? m_dst : -1;
         nx = m_regs;
         if (INC_EN && int'(INC_SEL) < NR) begin
            if (int'(INC_SEL) == busy_idx) e = 1;
            else nx[INC_SEL] = m_regs[INC_SEL] + DW'(1);
         end
         if (C_EN && int'(C_SEL) < NR) begin
            if (int'(C_SEL) == busy_idx) e = 1;
            else nx[C_SEL] = c_in;
         end
         if (m_pend) begin
            if (MEM_READ) e = 1;
            if (mem_valid) begin
               nx[m_dst] = DW'(mem_data);
               m_pend = 0;
            end else begin
               m_wait++;
               if (m_wait == TO) begin
                  e = 1;
                  m_pend = 0;
               end
            end
         end else if (MEM_READ) begin
            if (int'(MEM_DST) < NR) begin
               m_pend = 1; m_dst = int'(MEM_DST); m_wait = 0;
            end else begin
               e = 1;
            end
         end
         if (CLR && int'(CLR_SEL) < NR) nx[CLR_SEL] = '0;
         m_regs = nx;
         m_err = e;
      end
   end

   // Compare every output against the model once per cycle.
   always @(negedge clk) begin
      check("a_out", 32'(a_out), rd(A_SEL));
      check("b_out", 32'(b_out), rd(B_SEL));
      check("dm_addr", 32'(dm_addr), 32'(m_regs[0]));
      check("dm_data", 32'(dm_data), 32'(m_regs[1][MW-1:0]));
      check("rd_pending", 32'(rd_pending), 32'(m_pend));
      check("busy", 32'(busy), m_pend ? (32'd1 << m_dst) : 32'd0);
      check("err", 32'(err), 32'(m_err));
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_a", 32'(a_out), 32'h0);
      check("rst_dm_addr", 32'(dm_addr), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      RST = 1'b0;
      cyc();

      // Write then read; out-of-range select
      C_EN = 1'b1; C_SEL = 4'd3; c_in = 19'h5A5A5;
      cyc();
      quiet(); A_SEL = 4'd3;
      #1 check("wr_rd_reg3", 32'(a_out), 32'h5A5A5);
      A_SEL = 4'd15;
      #1 check("rd_sel15", 32'(a_out), 32'h0);

      // Mid-cycle reset abandons an in-flight load
      MEM_READ = 1'b1; MEM_DST = 4'd5;
      cyc();
      MEM_READ = 1'b0; A_SEL = 4'd3;
      #1 RST = 1'b1;
      #1;
      check("midrst_a", 32'(a_out), 32'h0);
      check("midrst_pend", 32'(rd_pending), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      RST = 1'b0;
      mem_valid = 1'b1; mem_data = 8'h99; A_SEL = 4'd5;
      cyc();
      mem_valid = 1'b0;
      #1 check("abandoned_load", 32'(a_out), 32'h0);

      // Load into reg1 with data after three wait cycles
      MEM_READ = 1'b1; MEM_DST = 4'd1;
      cyc();
      MEM_READ = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("load_pend", 32'(rd_pending), 32'h1);
         check("load_busy", 32'(busy), 32'h0002);
         if (k == 2) begin mem_valid = 1'b1; mem_data = 8'hC3; end
         cyc();
      end
      mem_valid = 1'b0; A_SEL = 4'd1;
      #1;
      check("load_reg1", 32'(a_out), 32'h000C3);
      check("load_dm_data", 32'(dm_data), 32'hC3);
      check("load_noerr", 32'(err), 32'h0);
      check("load_done", 32'(rd_pending), 32'h0);

      // Timeout: no data for TIMEOUT wait cycles
      C_EN = 1'b1; C_SEL = 4'd2; c_in = 19'h12345;
      cyc();
      quiet(); MEM_READ = 1'b1; MEM_DST = 4'd2;
      cyc();
      MEM_READ = 1'b0;
      repeat (TO - 1) cyc();
      check("to_still_pend", 32'(rd_pending), 32'h1);
      cyc();
      A_SEL = 4'd2;
      #1;
      check("to_err", 32'(err), 32'h1);
      check("to_busy", 32'(busy), 32'h0);
      check("to_reg2", 32'(a_out), 32'h12345);
      cyc();
      check("to_err_1cyc", 32'(err), 32'h0);

      // Data on the timeout edge wins
      MEM_READ = 1'b1; MEM_DST = 4'd2;
      cyc();
      MEM_READ = 1'b0;
      repeat (TO - 1) cyc();
      mem_valid = 1'b1; mem_data = 8'h5E;
      cyc();
      mem_valid = 1'b0;
      #1;
      check("to_edge_noerr", 32'(err), 32'h0);
      check("to_edge_reg2", 32'(a_out), 32'h0005E);

      // Priority CLR > C > INC, then C > INC
      C_EN = 1'b1; C_SEL = 4'd4; c_in = 19'h3C3C3;
      cyc();
      CLR = 1'b1; CLR_SEL = 4'd4; c_in = 19'h7FFFF; INC_EN = 1'b1; INC_SEL = 4'd4;
      cyc();
      CLR = 1'b0; A_SEL = 4'd4; c_in = 19'h00777;
      #1 check("prio_clr", 32'(a_out), 32'h0);
      cyc();
      quiet();
      #1 check("prio_c_over_inc", 32'(a_out), 32'h00777);

      // Hazards: C write to busy reg, MEM_READ during WAIT
      MEM_READ = 1'b1; MEM_DST = 4'd1;
      cyc();
      MEM_READ = 1'b0; C_EN = 1'b1; C_SEL = 4'd1; c_in = 19'h11111;
      cyc();
      C_EN = 1'b0;
      check("haz_c_err", 32'(err), 32'h1);
      MEM_READ = 1'b1; MEM_DST = 4'd6;
      cyc();
      MEM_READ = 1'b0;
      check("haz_rd_err", 32'(err), 32'h1);
      check("haz_busy", 32'(busy), 32'h0002);
      mem_valid = 1'b1; mem_data = 8'hA7;
      cyc();
      mem_valid = 1'b0; A_SEL = 4'd1; B_SEL = 4'd6;
      #1;
      check("haz_reg1", 32'(a_out), 32'h000A7);
      check("haz_reg6", 32'(b_out), 32'h0);

      // Increment wrap and pointer walk on reg0
      C_EN = 1'b1; C_SEL = 4'd0; c_in = 19'h7FFFF;
      cyc();
      quiet(); INC_EN = 1'b1; INC_SEL = 4'd0;
      cyc();
      check("inc_wrap", 32'(dm_addr), 32'h0);
      repeat (10) cyc();
      INC_EN = 1'b0;
      check("inc_walk", 32'(dm_addr), 32'd10);

      // Randomized traffic checked by the per-cycle compare
      for (int n = 0; n < 3000; n++) begin
         CLR       = ($urandom_range(0, 15) == 0);
         CLR_SEL   = SW'($urandom_range(0, 15));
         C_EN      = ($urandom_range(0, 2) == 0);
         C_SEL     = SW'($urandom_range(0, 15));
         c_in      = DW'($urandom);
         INC_EN    = ($urandom_range(0, 2) == 0);
         INC_SEL   = SW'($urandom_range(0, 15));
         MEM_READ  = ($urandom_range(0, 5) == 0);
         MEM_DST   = SW'($urandom_range(0, 15));
         mem_valid = ($urandom_range(0, 7) == 0);
         mem_data  = MW'($urandom);
         A_SEL     = SW'($urandom_range(0, 15));
         B_SEL     = SW'($urandom_range(0, 15));
         RST       = ($urandom_range(0, 499) == 0);
         cyc();
      end
      RST = 1'b0;
      quiet();
      cyc();
      cyc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
- Parametrised next-generation register file for the downsampling datapath.
- Provides NREGS registers of DATA_W bits, with two combinational read buses (A, B) and one C write bus.
- Adds a dedicated data-memory address register and write-data register, per-register synchronous clear, and auto-increment for pointer walking.
- Adds a handshaked memory-load path with a load scoreboard and a timeout.

Parameters:
- DATA_W, 19, register width in bits.
- MEM_W, 8, data-memory word width; must satisfy MEM_W <= DATA_W.
- NREGS, 14, number of registers.
- SEL_W, 4, select width; must satisfy 2^SEL_W >= NREGS.
- ADDR_REG, 0, index of the register driven onto dm_addr.
- DATA_REG, 1, index of the register whose low MEM_W bits drive dm_data.
- TIMEOUT, 15, maximum number of cycles the block waits for mem_valid.

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- RST, in, 1, asynchronous active-high reset; clears all state.
- CLR, in, 1, synchronous clear of one register.
- CLR_SEL, in, SEL_W, register index cleared by CLR.
- C_EN, in, 1, C bus write enable.
- C_SEL, in, SEL_W, C bus destination register.
- c_in, in, DATA_W, C bus write data.
- A_SEL, in, SEL_W, A bus read select.
- B_SEL, in, SEL_W, B bus read select.
- INC_EN, in, 1, increment enable.
- INC_SEL, in, SEL_W, register index to increment.
- MEM_READ, in, 1, one-cycle load request pulse.
- MEM_DST, in, SEL_W, load destination register.
- mem_valid, in, 1, memory returns data this cycle.
- mem_data, in, MEM_W, load data from memory.
- a_out, out, DATA_W, contents of register A_SEL.
- b_out, out, DATA_W, contents of register B_SEL.
- dm_addr, out, DATA_W, contents of regs[ADDR_REG].
- dm_data, out, MEM_W, regs[DATA_REG][MEM_W-1:0].
- rd_pending, out, 1, a load is outstanding.
- busy, out, NREGS, per-register load-pending scoreboard.
- err, out, 1, one-cycle error pulse.

Behaviour:
- Reset:
  - RST=1 asynchronously clears all registers, the FSM (to IDLE), the timeout counter and all flags.
  - While reset is held: a_out, b_out, dm_addr, dm_data = 0; rd_pending = 0; busy = 0; err = 0.
  - A load in flight when RST asserts is abandoned; no write occurs after reset releases.
- Reads:
  - a_out, b_out, dm_addr and dm_data are combinational from the register array.
  - A write becomes visible the cycle after its clock edge; there is no bypass/forwarding.
  - A select >= NREGS reads as 0.
- Write-port rules:
  - A write with a select >= NREGS is ignored.
  - Per-register priority in one cycle: CLR > memory load > C write > INC. Only the highest-priority source is applied; lower-priority sources targeting the same register are dropped silently.
  - Different registers may be written by different sources in the same cycle.
- INC: reg <= reg + 1, modulo 2^DATA_W. All-ones wraps to 0 with no flag.
- Load FSM, IDLE state:
  - MEM_READ=1 with MEM_DST < NREGS: latch MEM_DST, set busy[MEM_DST], set rd_pending, clear the counter, go to WAIT.
  - MEM_READ with MEM_DST >= NREGS: err pulse, stay in IDLE.
  - mem_valid in IDLE is ignored.
- Load FSM, WAIT state:
  - mem_valid=1: write the latched destination with {zeros, mem_data} (zero-extended), clear busy and rd_pending, go to IDLE. The destination register is visible the next cycle.
  - A new MEM_READ is accepted only from IDLE, so the earliest next request is the cycle after the return.
  - mem_valid=0: increment the counter. When the counter reaches TIMEOUT with no valid: err pulse, clear busy and rd_pending, go to IDLE; the destination register is unchanged.
  - mem_valid on the same edge that the counter reaches TIMEOUT: the data wins and there is no err.
  - MEM_READ while in WAIT: ignored, err pulse.
- Hazards:
  - A C write or INC to a register whose busy bit is set is dropped, with an err pulse.
  - CLR of the pending destination clears the register, but the load still completes and overwrites it.
- err is registered: it goes high one cycle after the offending edge and lasts one cycle. Multiple error causes in one cycle produce a single pulse.

Test Plan:
- Reset/reads: pulse RST mid-cycle -> all outputs 0 immediately. Write c_in=19'h5A5A5 to reg 3 -> a_out=19'h5A5A5 with A_SEL=3 on the next cycle. A_SEL=15 -> a_out=0.
- Load: MEM_READ with MEM_DST=1, then mem_valid after 3 cycles with mem_data=8'hC3 -> rd_pending and busy[1] high for 3 cycles, then reg1=19'h000C3, dm_data=8'hC3, no err.
- Timeout: MEM_READ with MEM_DST=2 and no mem_valid -> err pulse after 15 wait cycles, busy=0, reg2 unchanged. Repeat with mem_valid on the timeout edge -> data written, no err.
- Priority: in one cycle CLR with CLR_SEL=4, C_EN with C_SEL=4, INC with INC_SEL=4 -> reg4=0. Next cycle C_EN with C_SEL=4 and INC with INC_SEL=4 -> c_in written, increment dropped.
- Hazard: C write to reg 1 while a load into reg 1 is pending -> write dropped, err pulse. MEM_READ during WAIT -> err, original load completes intact.
- Wrap/auto-increment: reg0=19'h7FFFF, INC_SEL=0 -> dm_addr=0. Ten consecutive INC cycles -> dm_addr=10.
